// File: rtl/rv_pkg.sv
// rv_pkg: shared encodings for the RV32I pipeline.
//   - writeback-select codes (WB_*)
//   - load/store funct3 codes (F3_*)
//   - MEM-stage bus FSM state type
//   - helper that flags misaligned data accesses
package rv_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_RSV = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] gives the access size for both loads and stores.
  // Any code that is neither byte nor halfword is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic addrMisaligned(input logic [2:0] funct3,
                                          input logic [1:0] addrLo);
    logic result;
    result = 1'b0;
    if (funct3[1:0] == SZ_HALF) begin
      result = addrLo[0];
    end else if (funct3[1:0] != SZ_BYTE) begin
      result = (addrLo != 2'b00);
    end
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the MEM stage.
//   funct3      in  access width / signedness
//   addrLo      in  low two address bits
//   storeData   in  rs2 value for stores
//   rdata       in  word returned by the data bus
//   wdata       out store data replicated into the addressed lanes
//   wstrb       out byte strobes for the access (not yet gated by we)
//   loadData    out extracted and extended load value
//   misaligned  out access crosses its natural alignment
module lsu_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addrLo,
  input  logic [31:0]     storeData,
  input  logic [31:0]     rdata,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned
);

  logic [1:0] sizeCode;
  logic       isUnsigned;
  logic [7:0] byteSel;
  logic [15:0] halfSel;

  assign sizeCode   = funct3[1:0];
  assign isUnsigned = funct3[2];
  assign misaligned = addrMisaligned(funct3, addrLo);

  // Each lane picks its store byte and strobe independently: bytes are
  // replicated to all lanes, halfwords to both halves, words pass through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign wdata[gi*8 +: 8] = (sizeCode == SZ_BYTE) ? storeData[7:0] :
                                (sizeCode == SZ_HALF) ? storeData[(gi%2)*8 +: 8] :
                                                        storeData[gi*8 +: 8];
      assign wstrb[gi] = (sizeCode == SZ_BYTE) ? (addrLo == LANE) :
                         (sizeCode == SZ_HALF) ? (addrLo[1] == LANE[1]) :
                                                 1'b1;
    end
  endgenerate

  always_comb begin
    byteSel = rdata[7:0];
    unique case (addrLo)
      2'b00: byteSel = rdata[7:0];
      2'b01: byteSel = rdata[15:8];
      2'b10: byteSel = rdata[23:16];
      2'b11: byteSel = rdata[31:24];
    endcase
  end

  assign halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = XLEN'(rdata);
    if (sizeCode == SZ_BYTE) begin
      loadData = isUnsigned ? {{(XLEN-8){1'b0}}, byteSel}
                            : {{(XLEN-8){byteSel[7]}}, byteSel};
    end else if (sizeCode == SZ_HALF) begin
      loadData = isUnsigned ? {{(XLEN-16){1'b0}}, halfSel}
                            : {{(XLEN-16){halfSel[15]}}, halfSel};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and writeback stage of the RV32I pipeline.
//   EX/MEM inputs : regwriteM, memrwM, wbselM, funct3M, rdM,
//                   aluresultM, writedataM, pc4M
//   data bus      : dmem_req/we/addr/wdata/wstrb out, dmem_rdata/ack in
//   stallM        : holds EX/MEM and everything upstream while waiting
//   W outputs     : regwriteW, rdW, resultW (register-file write port),
//                   misalignW (one-cycle flag for a dropped access)
module mem_wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwriteM,
  input  logic              memrwM,
  input  logic [1:0]        wbselM,
  input  logic [2:0]        funct3M,
  input  logic [4:0]        rdM,
  input  logic [XLEN-1:0]   aluresultM,
  input  logic [XLEN-1:0]   writedataM,
  input  logic [XLEN-1:0]   pc4M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stallM,
  output logic              regwriteW,
  output logic [4:0]        rdW,
  output logic [XLEN-1:0]   resultW,
  output logic              misalignW
);

  mem_state_e state_reg, state_next;

  logic            isLoad;
  logic            isStore;
  logic            memOp;
  logic            addrBad;
  logic            misalign;
  logic            reqActive;
  logic [31:0]     laneWdata;
  logic [3:0]      laneStrb;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] result;

  assign isLoad  = regwriteM && (wbselM == WB_MEM) && !memrwM;
  assign isStore = memrwM;
  assign memOp   = isLoad || isStore;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3    (funct3M),
    .addrLo    (aluresultM[1:0]),
    .storeData (writedataM[31:0]),
    .rdata     (dmem_rdata),
    .wdata     (laneWdata),
    .wstrb     (laneStrb),
    .loadData  (loadData),
    .misaligned(addrBad)
  );

  assign misalign = memOp && addrBad;

  // The request is combinational from the held EX/MEM bundle, so it is the
  // same in IDLE and WAIT. Gating with rst_n drops it immediately when reset
  // lands mid-access, rather than at the next edge.
  assign reqActive  = memOp && !misalign && rst_n;
  assign dmem_req   = reqActive;
  assign dmem_we    = reqActive && isStore;
  assign dmem_addr  = {aluresultM[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = laneWdata;
  assign dmem_wstrb = dmem_we ? laneStrb : 4'b0000;

  // An ack with no request in flight is ignored because it only matters
  // through reqActive.
  assign stallM = reqActive && !dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (reqActive && !dmem_ack) state_next = S_WAIT;
      S_WAIT: if (!reqActive || dmem_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (wbselM)
      WB_MEM:  result = loadData;
      WB_ALU:  result = aluresultM;
      WB_PC4:  result = pc4M;
      default: result = '0;
    endcase
  end

  // MEM/WB register: a stalled cycle retires a bubble so decode never sees
  // a half-finished load; a misaligned access retires as a flagged bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW <= 1'b0;
      rdW       <= '0;
      resultW   <= '0;
      misalignW <= 1'b0;
    end else if (stallM) begin
      regwriteW <= 1'b0;
      rdW       <= '0;
      resultW   <= '0;
      misalignW <= 1'b0;
    end else begin
      regwriteW <= regwriteM && (rdM != 5'd0) && !misalign;
      rdW       <= rdM;
      resultW   <= result;
      misalignW <= misalign;
    end
  end

endmodule
